// File: rtl/piso_pkg.sv
// Shared constants for the 4-bit parallel-in / two-wire serial transmitter:
// frame width and the FSM state encoding exported on the debug port.
package piso_pkg;

  localparam int FRAME_W = 4;

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] START  = 4'd1;
  localparam logic [3:0] B3_L   = 4'd2;
  localparam logic [3:0] B3_H   = 4'd3;
  localparam logic [3:0] B2_L   = 4'd4;
  localparam logic [3:0] B2_H   = 4'd5;
  localparam logic [3:0] B1_L   = 4'd6;
  localparam logic [3:0] B1_H   = 4'd7;
  localparam logic [3:0] B0_L   = 4'd8;
  localparam logic [3:0] B0_H   = 4'd9;
  localparam logic [3:0] STOP_L = 4'd10;
  localparam logic [3:0] STOP_H = 4'd11;

endpackage

// File: rtl/piso_i2c_tx.sv
// Captures a 4-bit word on d_en and sends START, 4 bits MSB-first, STOP on scl/sda.
// scl/sda are decoded from the next state so they register alongside state.
module piso_i2c_tx
  import piso_pkg::*;
(
  input  logic               sclk,
  input  logic               rst,
  input  logic               d_en,
  input  logic [FRAME_W-1:0] data,
  output logic               scl,
  output logic               sda,
  output logic [3:0]         state
);

  logic [3:0]         next_state;
  logic               next_scl;
  logic               next_sda;
  logic               load;
  logic [FRAME_W-1:0] sr;

  // State, line and shift-register flops; reset aborts any frame without a STOP.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      scl   <= 1'b1;
      sda   <= 1'b1;
      sr    <= {FRAME_W{1'b0}};
    end else begin
      state <= next_state;
      scl   <= next_scl;
      sda   <= next_sda;
      if (load) begin
        sr <= data;
      end else begin
        sr <= sr;
      end
    end
  end

  // Next-state logic: only IDLE looks at d_en; every other phase lasts one cycle.
  always_comb begin
    next_state = IDLE;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (d_en) begin
          next_state = START;
          load       = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      START:   next_state = B3_L;
      B3_L:    next_state = B3_H;
      B3_H:    next_state = B2_L;
      B2_L:    next_state = B2_H;
      B2_H:    next_state = B1_L;
      B1_L:    next_state = B1_H;
      B1_H:    next_state = B0_L;
      B0_L:    next_state = B0_H;
      B0_H:    next_state = STOP_L;
      STOP_L:  next_state = STOP_H;
      STOP_H:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Line decode for the state about to be entered; sr is stable through all bit phases.
  always_comb begin
    next_scl = 1'b1;
    next_sda = 1'b1;
    case (next_state)
      IDLE:    begin next_scl = 1'b1; next_sda = 1'b1;  end
      START:   begin next_scl = 1'b1; next_sda = 1'b0;  end
      B3_L:    begin next_scl = 1'b0; next_sda = sr[3]; end
      B3_H:    begin next_scl = 1'b1; next_sda = sr[3]; end
      B2_L:    begin next_scl = 1'b0; next_sda = sr[2]; end
      B2_H:    begin next_scl = 1'b1; next_sda = sr[2]; end
      B1_L:    begin next_scl = 1'b0; next_sda = sr[1]; end
      B1_H:    begin next_scl = 1'b1; next_sda = sr[1]; end
      B0_L:    begin next_scl = 1'b0; next_sda = sr[0]; end
      B0_H:    begin next_scl = 1'b1; next_sda = sr[0]; end
      STOP_L:  begin next_scl = 1'b0; next_sda = 1'b0;  end
      STOP_H:  begin next_scl = 1'b1; next_sda = 1'b0;  end
      default: begin next_scl = 1'b1; next_sda = 1'b1;  end
    endcase
  end

endmodule

// File: tb/tb_piso_i2c_tx.sv
// Self-checking bench for piso_i2c_tx: scenario tasks check state/lines inline,
// a scoreboard queue holds the serial bits expected on each scl-high data phase.
module tb_piso_i2c_tx;

  logic       sclk;
  logic       rst;
  logic       d_en;
  logic [3:0] data;
  logic       scl;
  logic       sda;
  logic [3:0] state;

  int   nchecks = 0;
  int   nfail   = 0;
  logic exp_q[$];

  piso_i2c_tx dut (
    .sclk (sclk),
    .rst  (rst),
    .d_en (d_en),
    .data (data),
    .scl  (scl),
    .sda  (sda),
    .state(state)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Scoreboard: every scl-high data phase must present the next queued bit.
  always @(negedge sclk) begin
    logic b;
    if (rst === 1'b1 && scl === 1'b1 &&
        (state == 4'd3 || state == 4'd5 || state == 4'd7 || state == 4'd9)) begin
      nchecks++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL bit_unexpected: sda=%0b in state %0d, no bit expected", sda, state);
      end else begin
        b = exp_q.pop_front();
        if (sda !== b) begin
          nfail++;
          $display("FAIL serial_bit: state %0d sda=%0b expected %0b", state, sda, b);
        end
      end
    end
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic push_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    d_en = 1'b1;
    data = 4'hF;
    for (int c = 0; c < 2; c++) begin
      step();
      nchecks++;
      if (state !== 4'd0 || scl !== 1'b1 || sda !== 1'b1) begin
        nfail++;
        $display("FAIL reset_hold: state=%0d scl=%0b sda=%0b expected 0/1/1", state, scl, sda);
      end
    end
    d_en = 1'b0;
    rst  = 1'b1;
    step();
    nchecks++;
    if (state !== 4'd0) begin
      nfail++;
      $display("FAIL reset_release_idle: state=%0d expected 0", state);
    end
  endtask

  task automatic test_single_frame();
    data = 4'b1101;
    d_en = 1'b1;
    push_word(4'b1101);
    step();
    d_en = 1'b0;
    nchecks++;
    if (state !== 4'd1 || scl !== 1'b1 || sda !== 1'b0) begin
      nfail++;
      $display("FAIL start_cond: state=%0d scl=%0b sda=%0b expected 1/1/0", state, scl, sda);
    end
    for (int k = 2; k <= 11; k++) begin
      step();
      nchecks++;
      if (state !== k[3:0] || scl !== k[0]) begin
        nfail++;
        $display("FAIL frame_step: state=%0d scl=%0b expected %0d/%0b", state, scl, k, k[0]);
      end
    end
    nchecks++;
    if (sda !== 1'b0) begin
      nfail++;
      $display("FAIL stop_low: sda=%0b expected 0 in STOP_H", sda);
    end
    step();
    nchecks++;
    if (state !== 4'd0 || scl !== 1'b1 || sda !== 1'b1) begin
      nfail++;
      $display("FAIL stop_rise: state=%0d scl=%0b sda=%0b expected 0/1/1", state, scl, sda);
    end
    nchecks++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL single_bits_left: %0d bits not emitted, expected 0", exp_q.size());
    end
  endtask

  task automatic test_busy_ignore();
    int cycles;
    data = 4'b1101;
    d_en = 1'b1;
    push_word(4'b1101);
    step();
    d_en = 1'b0;
    for (int k = 0; k < 4; k++) step();
    nchecks++;
    if (state !== 4'd5) begin
      nfail++;
      $display("FAIL busy_reach5: state=%0d expected 5", state);
    end
    data = 4'b0010;
    d_en = 1'b1;
    step();
    d_en = 1'b0;
    cycles = 0;
    while (state != 4'd0 && cycles < 20) begin
      step();
      cycles++;
    end
    nchecks++;
    if (cycles != 6) begin
      nfail++;
      $display("FAIL busy_frame_end: returned to idle after %0d cycles, expected 6", cycles);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      nchecks++;
      if (state !== 4'd0) begin
        nfail++;
        $display("FAIL busy_no_new_frame: state=%0d expected 0", state);
      end
    end
    nchecks++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL busy_bits_left: %0d bits not emitted, expected 0", exp_q.size());
    end
  endtask

  task automatic test_repeat();
    int busy;
    for (int f = 0; f < 3; f++) begin
      data = 4'b1101;
      d_en = 1'b1;
      push_word(4'b1101);
      step();
      d_en = 1'b0;
      busy = 0;
      for (int c = 0; c < 50; c++) begin
        if (state != 4'd0) busy++;
        if (c < 49) step();
      end
      nchecks++;
      if (busy != 11) begin
        nfail++;
        $display("FAIL repeat_len: frame %0d busy %0d cycles, expected 11", f, busy);
      end
      nchecks++;
      if (state !== 4'd0) begin
        nfail++;
        $display("FAIL repeat_gap_idle: frame %0d state=%0d expected 0", f, state);
      end
    end
    nchecks++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL repeat_bits_left: %0d bits not emitted, expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    data = 4'b1010;
    d_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      push_word(4'b1010);
      for (int k = 1; k <= 11; k++) begin
        step();
        nchecks++;
        if (state !== k[3:0]) begin
          nfail++;
          $display("FAIL held_step: frame %0d state=%0d expected %0d", f, state, k);
        end
      end
      step();
      nchecks++;
      if (state !== 4'd0 || sda !== 1'b1) begin
        nfail++;
        $display("FAIL held_gap: frame %0d state=%0d sda=%0b expected 0/1", f, state, sda);
      end
    end
    d_en = 1'b0;
    step();
    nchecks++;
    if (state !== 4'd0) begin
      nfail++;
      $display("FAIL held_release: state=%0d expected 0", state);
    end
    nchecks++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL held_bits_left: %0d bits not emitted, expected 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    data = 4'b0110;
    d_en = 1'b1;
    push_word(4'b0110);
    step();
    d_en = 1'b0;
    for (int k = 0; k < 5; k++) step();
    nchecks++;
    if (state !== 4'd6) begin
      nfail++;
      $display("FAIL abort_reach6: state=%0d expected 6", state);
    end
    #1;
    rst = 1'b0;
    #1;
    nchecks++;
    if (state !== 4'd0 || scl !== 1'b1 || sda !== 1'b1) begin
      nfail++;
      $display("FAIL abort_immediate: state=%0d scl=%0b sda=%0b expected 0/1/1", state, scl, sda);
    end
    nchecks++;
    if (exp_q.size() != 2) begin
      nfail++;
      $display("FAIL abort_bits_sent: %0d bits pending, expected 2", exp_q.size());
    end
    exp_q.delete();
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      nchecks++;
      if (state !== 4'd0 || sda !== 1'b1) begin
        nfail++;
        $display("FAIL abort_quiet: state=%0d sda=%0b expected 0/1", state, sda);
      end
    end
    data = 4'b1001;
    d_en = 1'b1;
    push_word(4'b1001);
    step();
    d_en = 1'b0;
    nchecks++;
    if (state !== 4'd1) begin
      nfail++;
      $display("FAIL abort_fresh_start: state=%0d expected 1", state);
    end
    for (int k = 0; k < 11; k++) step();
    nchecks++;
    if (state !== 4'd0 || exp_q.size() != 0) begin
      nfail++;
      $display("FAIL abort_fresh_frame: state=%0d pending=%0d expected 0/0", state, exp_q.size());
    end
  endtask

  initial begin
    rst  = 1'b0;
    d_en = 1'b0;
    data = 4'h0;
    test_reset();
    test_single_frame();
    test_busy_ignore();
    test_repeat();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
